// File: rtl/sum_tree_pkg.sv
// Shared definitions for the pipelined signed adder tree with channel accumulation.
//   clog2        : ceiling log2, used to size the tree depth
//   level_count  : number of operands still alive after a given number of tree levels
//   L/TREE_W/ACC_W : derived widths for the default 9 x 21-bit configuration
//   sat_trunc    : clamps or wraps a wide signed value into an output width, {ovf, result}
//   acc_state_e  : accumulator FSM states
package sum_tree_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Each level halves the operand count, rounding up for an odd trailing operand.
  function automatic int level_count(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

  localparam int N_IN_DEF    = 9;
  localparam int IN_W_DEF    = 21;
  localparam int ACC_EXT_DEF = 8;
  localparam int L           = clog2(N_IN_DEF);
  localparam int TREE_W      = IN_W_DEF + L;
  localparam int ACC_W       = TREE_W + ACC_EXT_DEF;

  // Bit 64 of the return value is the overflow flag; bits 63:0 hold the result
  // sign-extended, so the caller keeps only its low out_w bits.
  function automatic logic [64:0] sat_trunc(input logic signed [63:0] value,
                                            input int out_w,
                                            input bit sat);
    logic signed [63:0] maxv;
    logic signed [63:0] minv;
    logic signed [63:0] res;
    logic               ovf;
    maxv = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    minv = -maxv - 64'sd1;
    res  = value;
    ovf  = 1'b0;
    if (sat) begin
      if (value > maxv) begin
        res = maxv;
        ovf = 1'b1;
      end else if (value < minv) begin
        res = minv;
        ovf = 1'b1;
      end
    end else begin
      // Keep the low bits, re-sign-extend, and flag any difference as lost upper bits.
      res = (value <<< (64 - out_w)) >>> (64 - out_w);
      ovf = (res != value);
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/sum_tree_level.sv
// One registered reduction level of the adder tree.
//   clk, rst        : clock and synchronous active-high reset
//   en_i            : advance enable; the level holds its contents while low
//   valid_i/first_i/last_i : sideband travelling with the beat
//   data_i          : N packed operands of W bits
//   valid_o/first_o/last_o : registered sideband
//   data_o          : ceil(N/2) packed partial sums of W bits
module sum_tree_level
  import sum_tree_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic                       valid_i,
  input  logic                       first_i,
  input  logic                       last_i,
  input  logic [N*W-1:0]             data_i,
  output logic                       valid_o,
  output logic                       first_o,
  output logic                       last_o,
  output logic [((N+1)/2)*W-1:0]     data_o
);

  localparam int NOut = (N + 1) / 2;

  logic [NOut*W-1:0] sum_d;
  logic [NOut*W-1:0] data_q;
  logic              valid_q;
  logic              first_q;
  logic              last_q;

  // Pairwise adds; an odd trailing operand is forwarded unchanged. Operands are
  // already at the full tree width, so the add cannot overflow.
  for (genvar k = 0; k < NOut; k++) begin : g_pair
    if (2 * k + 1 < N) begin : g_add
      assign sum_d[k*W +: W] = data_i[2*k*W +: W] + data_i[(2*k+1)*W +: W];
    end else begin : g_pass
      assign sum_d[k*W +: W] = data_i[2*k*W +: W];
    end
  end

  // Level register: data and sideband move together, and everything freezes
  // while the downstream stage is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      first_q <= first_i;
      last_q  <= last_i;
      data_q  <= sum_d;
    end
  end

  assign valid_o = valid_q;
  assign first_o = first_q;
  assign last_o  = last_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sum_tree_acc.sv
// Pipelined signed adder tree with group accumulation and saturating output.
//   clk, rst             : clock and synchronous active-high reset
//   in_valid, in_ready   : input handshake, one beat of N_IN addends per transfer
//   in_data              : packed signed addends, addend k at [k*IN_W +: IN_W]
//   in_first, in_last    : group delimiters (both set = one-beat group)
//   out_valid, out_ready : output handshake
//   out_sum              : group result, OUT_W bits signed
//   out_ovf              : result was clamped (SAT=1) or wrapped (SAT=0)
module sum_tree_acc
  import sum_tree_pkg::*;
#(
  parameter int N_IN    = 9,
  parameter int IN_W    = 21,
  parameter int OUT_W   = 21,
  parameter int ACC_EXT = 8,
  parameter int SAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*IN_W-1:0]    in_data,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_sum,
  output logic                    out_ovf
);

  localparam int LV = clog2(N_IN);
  localparam int TW = IN_W + LV;
  localparam int AW = TW + ACC_EXT;

  logic              stall;
  logic              advance;
  logic [N_IN*TW-1:0] treeIn;

  logic              treeValid;
  logic              treeFirst;
  logic              treeLast;
  logic signed [TW-1:0] treeSum;
  logic signed [AW-1:0] treeExt;

  acc_state_e        state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] accNext;
  logic              emit;
  logic [64:0]       satRes;

  logic              outValid_q, outValid_d;
  logic signed [OUT_W-1:0] outSum_q, outSum_d;
  logic              outOvf_q, outOvf_d;

  // A single global stall: a result waiting on the consumer freezes the whole pipe.
  assign stall    = outValid_q && !out_ready;
  assign advance  = !stall;
  assign in_ready = advance;

  // Widen every addend to the tree width up front so all levels share one width.
  for (genvar k = 0; k < N_IN; k++) begin : g_ext
    assign treeIn[k*TW +: TW] = TW'($signed(in_data[k*IN_W +: IN_W]));
  end

  for (genvar j = 0; j < LV; j++) begin : g_lvl
    localparam int NI = level_count(N_IN, j);
    localparam int NO = (NI + 1) / 2;
    logic [NO*TW-1:0] data;
    logic             valid;
    logic             first;
    logic             last;
    if (j == 0) begin : g_head
      sum_tree_level #(.N(NI), .W(TW)) u_level (
        .clk     (clk),
        .rst     (rst),
        .en_i    (advance),
        .valid_i (in_valid),
        .first_i (in_first),
        .last_i  (in_last),
        .data_i  (treeIn),
        .valid_o (valid),
        .first_o (first),
        .last_o  (last),
        .data_o  (data)
      );
    end else begin : g_body
      sum_tree_level #(.N(NI), .W(TW)) u_level (
        .clk     (clk),
        .rst     (rst),
        .en_i    (advance),
        .valid_i (g_lvl[j-1].valid),
        .first_i (g_lvl[j-1].first),
        .last_i  (g_lvl[j-1].last),
        .data_i  (g_lvl[j-1].data),
        .valid_o (valid),
        .first_o (first),
        .last_o  (last),
        .data_o  (data)
      );
    end
  end

  assign treeValid = g_lvl[LV-1].valid;
  assign treeFirst = g_lvl[LV-1].first;
  assign treeLast  = g_lvl[LV-1].last;
  assign treeSum   = g_lvl[LV-1].data;
  assign treeExt   = AW'(treeSum);

  // Accumulator FSM. From IDLE any beat opens a group regardless of first; inside
  // a group a new first drops the partial sum. A last beat emits the running total
  // including itself and returns to IDLE. Invalid slots leave everything alone.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    accNext = acc_q;
    emit    = 1'b0;
    if (treeValid) begin
      if (state_q == IDLE || treeFirst) begin
        accNext = treeExt;
      end else begin
        accNext = acc_q + treeExt;
      end
      acc_d   = accNext;
      state_d = ACCUM;
      if (treeLast) begin
        emit    = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // Output register inputs. Whenever the pipe advances, any previous result has
  // either been taken or was never present, so valid simply follows emit.
  always_comb begin
    satRes     = sat_trunc(64'(accNext), OUT_W, SAT != 0);
    outValid_d = emit;
    outSum_d   = outSum_q;
    outOvf_d   = outOvf_q;
    if (emit) begin
      outSum_d = OUT_W'(satRes[63:0]);
      outOvf_d = satRes[64];
    end
  end

  // Accumulator, FSM and output registers all hold together with the tree.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      outValid_q <= 1'b0;
      outSum_q   <= '0;
      outOvf_q   <= 1'b0;
    end else if (advance) begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      outValid_q <= outValid_d;
      outSum_q   <= outSum_d;
      outOvf_q   <= outOvf_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_sum   = outSum_q;
  assign out_ovf   = outOvf_q;

endmodule

// File: tb/tb_sum_tree_acc.sv
// Self-checking bench for sum_tree_acc in its default 9 x 21-bit saturating configuration.
module tb_sum_tree_acc;

  localparam int N_IN    = 9;
  localparam int IN_W    = 21;
  localparam int OUT_W   = 21;
  localparam int ACC_EXT = 8;
  localparam int LATENCY = 5;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_first = 1'b0;
  logic                    in_last = 1'b0;
  logic [N_IN*IN_W-1:0]    in_data = '0;
  logic                    out_ready = 1'b1;
  logic                    in_ready;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_sum;
  logic                    out_ovf;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic signed [OUT_W-1:0] sum;
    logic                    ovf;
  } exp_t;

  exp_t sb[$];

  sum_tree_acc #(
    .N_IN    (N_IN),
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .ACC_EXT (ACC_EXT),
    .SAT     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every handshaken result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      assertions++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_output: got sum=%0d ovf=%0b, required no output", out_sum, out_ovf);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_sum !== e.sum || out_ovf !== e.ovf) begin
          failures++;
          $display("[TB] FAIL result: got sum=%0d ovf=%0b, required sum=%0d ovf=%0b",
                   out_sum, out_ovf, e.sum, e.ovf);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [N_IN*IN_W-1:0] packAll(input int v);
    logic [N_IN*IN_W-1:0] d;
    for (int k = 0; k < N_IN; k++) d[k*IN_W +: IN_W] = IN_W'(v);
    return d;
  endfunction

  // Beat summing to s: s in addend 0, a cancelling +3/-3 pair, zeros elsewhere.
  function automatic logic [N_IN*IN_W-1:0] packOne(input int s);
    logic [N_IN*IN_W-1:0] d;
    d = '0;
    d[0 +: IN_W]      = IN_W'(s);
    d[IN_W +: IN_W]   = IN_W'(3);
    d[2*IN_W +: IN_W] = IN_W'(-3);
    return d;
  endfunction

  // Addends 1,-2,3,-4,5,-6,7,-8,9 which sum to 5.
  function automatic logic [N_IN*IN_W-1:0] packAlt();
    logic [N_IN*IN_W-1:0] d;
    for (int k = 0; k < N_IN; k++) d[k*IN_W +: IN_W] = IN_W'((k % 2 == 1) ? -(k + 1) : (k + 1));
    return d;
  endfunction

  task automatic pushExp(input int s, input logic o);
    exp_t e;
    e.sum = OUT_W'(s);
    e.ovf = o;
    sb.push_back(e);
  endtask

  // Drives one beat and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [N_IN*IN_W-1:0] d, input logic f, input logic l);
    int waitCnt;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    in_last  = l;
    waitCnt  = 0;
    while (!in_ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      assertions++;
      failures++;
      $display("[TB] FAIL accept_timeout: got in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic idleInputs();
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    assertions++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got valid=%0b sum=%0d ovf=%0b, required 0 0 0", out_valid, out_sum, out_ovf);
    end
    rst = 1'b0;
    #1;
    assertions++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_single_beat();
    int lat;
    pushExp(9, 1'b0);
    applyStimulus(packAll(1), 1'b1, 1'b1);
    idleInputs();
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (out_valid && lat == 0) lat = n;
    end
    assertions++;
    if (lat != LATENCY) begin
      failures++;
      $display("[TB] FAIL latency: got %0d cycles, required %0d", lat, LATENCY);
    end
    pushExp(5, 1'b0);
    applyStimulus(packAlt(), 1'b1, 1'b1);
    idleInputs();
    waitDrain();
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL single_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_multi_beat();
    pushExp(67, 1'b0);
    applyStimulus(packOne(100), 1'b1, 1'b0);
    applyStimulus(packOne(-40), 1'b0, 1'b0);
    applyStimulus(packOne(7), 1'b0, 1'b1);
    idleInputs();
    waitDrain();
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL multi_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_saturation();
    pushExp((1 << 20) - 1, 1'b1);
    for (int b = 0; b < 4; b++) applyStimulus(packAll((1 << 20) - 1), b == 0, b == 3);
    pushExp(-(1 << 20), 1'b1);
    for (int b = 0; b < 4; b++) applyStimulus(packAll(-(1 << 20)), b == 0, b == 3);
    idleInputs();
    waitDrain();
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL sat_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          pushExp(i * 7 - 30, 1'b0);
          applyStimulus(packOne(i * 7 - 30), 1'b1, 1'b1);
        end
        idleInputs();
      end
      begin
        logic signed [OUT_W-1:0] held;
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b0;
        held = out_sum;
        repeat (3) begin
          @(negedge clk);
          assertions++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== held) begin
            failures++;
            $display("[TB] FAIL stall_hold: got in_ready=%0b valid=%0b sum=%0d, required 0 1 %0d",
                     in_ready, out_valid, out_sum, held);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        assertions++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("[TB] FAIL stall_release: got in_ready=%0b, required 1", in_ready);
        end
      end
    join
    waitDrain();
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL stream_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_restart();
    pushExp(6, 1'b0);
    applyStimulus(packOne(50), 1'b1, 1'b0);
    applyStimulus(packOne(5), 1'b1, 1'b0);
    applyStimulus(packOne(1), 1'b0, 1'b1);
    idleInputs();
    waitDrain();
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL restart_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(packOne(40), 1'b1, 1'b0);
    applyStimulus(packOne(41), 1'b0, 1'b0);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    assertions++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got valid=%0b sum=%0d ovf=%0b, required 0 0 0", out_valid, out_sum, out_ovf);
    end
    repeat (10) @(negedge clk);
    pushExp(12, 1'b0);
    applyStimulus(packOne(12), 1'b1, 1'b1);
    idleInputs();
    waitDrain();
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL midreset_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_saturation();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
